forward_hazard_unit: RTL and testbench
======================================

Name: forward_hazard_unit

Overview:
Parametrised successor to the EX-stage operand forwarding mux. Selects each ALU operand from NUM_SRC prioritised in-flight write ports, never forwards register 0, and adds a load-use hazard detector. The detector is a stall state machine that holds ID and injects EX bubbles for a configurable load latency, and it also counts stall cycles. Sits between ID/EX and the EX-stage ALU; stall and bubble outputs drive the pipeline control.

Parameters:
DATA_WIDTH, 32, operand/data width
REG_ADDR_WIDTH, 5, register address width
NUM_SRC, 4, forwarding write ports; index 0 = youngest = highest priority
LOAD_LAT, 1, stall cycles per load-use hazard (>=1)
CNT_WIDTH, 16, stall statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_in  in  1  pipeline flush; aborts any stall
data_alu_a_in  in  DATA_WIDTH  register-file operand A
data_alu_b_in  in  DATA_WIDTH  register-file operand B
addr_alu_a_in  in  REG_ADDR_WIDTH  EX operand A address
addr_alu_b_in  in  REG_ADDR_WIDTH  EX operand B address
fwd_addr_in  in  NUM_SRC*REG_ADDR_WIDTH  packed write addresses, slice i = source i
fwd_data_in  in  NUM_SRC*DATA_WIDTH  packed write data
fwd_wr_ena_in  in  NUM_SRC  per-source write enable
id_valid_in  in  1  valid instruction in ID
id_addr_a_in  in  REG_ADDR_WIDTH  ID source A
id_addr_b_in  in  REG_ADDR_WIDTH  ID source B
id_use_a_in  in  1  ID instruction reads A
id_use_b_in  in  1  ID instruction reads B
ex_load_in  in  1  valid load in EX
ex_load_dest_in  in  REG_ADDR_WIDTH  load destination
alu_a_out  out  DATA_WIDTH  forwarded operand A
alu_b_out  out  DATA_WIDTH  forwarded operand B
fwd_hit_a_out  out  1  operand A taken from a forwarding source
fwd_hit_b_out  out  1  operand B taken from a forwarding source
stall_out  out  1  hold PC and IF/ID
bubble_out  out  1  insert NOP into ID/EX (always equals stall_out)
stall_cnt_out  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Forwarding is combinational and applies identically to port A and port B.
- Port A selects the lowest i where fwd_wr_ena_in[i] is 1, fwd_addr slice i equals addr_alu_a_in, and addr_alu_a_in != 0. Otherwise it passes data_alu_a_in through. fwd_hit_a_out = 1 iff a source was selected.
- Address 0 never matches any source; alu_x_out = data_alu_x_in for address 0.
- Hazard (combinational) = id_valid_in & ex_load_in & ex_load_dest_in != 0 & ((id_use_a_in & id_addr_a_in == ex_load_dest_in) | (id_use_b_in & id_addr_b_in == ex_load_dest_in)).
- FSM states: IDLE, WAIT. Down-counter cnt, width clog2(LOAD_LAT+1).
- IDLE: stall_out = hazard & !flush_in. If stall_out and LOAD_LAT > 1, go to WAIT with cnt = LOAD_LAT-1; otherwise stay in IDLE.
- WAIT: stall_out = !flush_in. cnt decrements each cycle. Return to IDLE on the cycle cnt==1 is consumed. New hazards are ignored while in WAIT.
- Each hazard therefore gives exactly LOAD_LAT consecutive stall cycles.
- flush_in has priority in every state: stall_out = 0 in that same cycle; next state IDLE, cnt = 0.
- stall_cnt_out increments on each clock edge where stall_out = 1, and saturates at all-ones.
- Reset (asynchronous, any time including mid-stall): state IDLE, cnt 0, stall_cnt_out 0.
- While rst_n = 0, stall_out and bubble_out are 0. Forwarding outputs stay purely combinational and are unaffected by reset.

Decomposition:
- Shared package: state encoding (IDLE/WAIT) and a REG_ZERO address constant.
- One sub-module, fwd_prio_mux (NUM_SRC priority compare-and-select). It is instantiated twice, for port A and port B.
- The FSM and counters live in the top module.

Test Plan:
1. Reset, NUM_SRC=4: hold rst_n=0 -> stall_out=0, stall_cnt_out=0. Release reset, no enables, data_alu_a_in=0x11 -> alu_a_out=0x11, fwd_hit_a_out=0.
2. addr_alu_a_in=5; sources 1 and 3 both write r5 with 0xAA and 0xBB -> alu_a_out=0xAA. Disable source 1 -> 0xBB.
3. addr_alu_b_in=0; source 0 writes r0 with 0xFF, data_alu_b_in=0x0 -> alu_b_out=0x0, fwd_hit_b_out=0.
4. LOAD_LAT=1: ex_load_in=1, dest=7; ID reads r7 on A -> stall_out=bubble_out=1 for exactly 1 cycle, stall_cnt_out=1. Same stimulus with id_use_a_in=0 -> no stall.
5. LOAD_LAT=3: hazard on B -> 3 consecutive stall cycles, then 0. Second run: assert flush_in in stall cycle 2 -> stall_out=0 that cycle, FSM in IDLE, stall_cnt_out=1 after the run.
6. CNT_WIDTH=4: 20 stall cycles -> stall_cnt_out saturates at 15. Assert rst_n=0 mid-WAIT -> state IDLE, count 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding and load-use hazard logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package forward_hazard_unit_pkg;

    // Stall FSM: IDLE watches for load-use hazards, WAIT burns the remaining load latency.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fsm_state_t;

    // Architectural zero register: never written, so never a forwarding target.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/forward_hazard_unit_fwd_prio_mux.sv
// Priority compare-and-select of one ALU operand across NUM_SRC in-flight write ports.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs every cycle.
module fwd_prio_mux
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 4
) (
    input  logic [REG_ADDR_WIDTH-1:0]         addr,
    input  logic [DATA_WIDTH-1:0]             rf_data,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] fwd_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     fwd_data,
    input  logic [NUM_SRC-1:0]                fwd_wr_ena,
    output logic [DATA_WIDTH-1:0]             data,
    output logic                              hit
);

    // Scan oldest to youngest so the lowest matching index (youngest) overrides the rest.
    always_comb begin
        data = rf_data;
        hit  = 1'b0;
        if (addr != REG_ADDR_WIDTH'(REG_ZERO)) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (fwd_wr_ena[i] && (fwd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr)) begin
                    data = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    hit  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// EX operand forwarding for A/B plus load-use stall FSM with saturating stall-cycle counter.
// Latency: forwarding and stall_out are combinational; FSM and counter update on the next edge.
// Backpressure: stall_out/bubble_out hold ID and bubble EX for LOAD_LAT cycles per hazard; flush aborts.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_SRC        = 4,
    parameter int LOAD_LAT       = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_in,
    input  logic [DATA_WIDTH-1:0]             data_alu_a_in,
    input  logic [DATA_WIDTH-1:0]             data_alu_b_in,
    input  logic [REG_ADDR_WIDTH-1:0]         addr_alu_a_in,
    input  logic [REG_ADDR_WIDTH-1:0]         addr_alu_b_in,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] fwd_addr_in,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     fwd_data_in,
    input  logic [NUM_SRC-1:0]                fwd_wr_ena_in,
    input  logic                              id_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0]         id_addr_a_in,
    input  logic [REG_ADDR_WIDTH-1:0]         id_addr_b_in,
    input  logic                              id_use_a_in,
    input  logic                              id_use_b_in,
    input  logic                              ex_load_in,
    input  logic [REG_ADDR_WIDTH-1:0]         ex_load_dest_in,
    output logic [DATA_WIDTH-1:0]             alu_a_out,
    output logic [DATA_WIDTH-1:0]             alu_b_out,
    output logic                              fwd_hit_a_out,
    output logic                              fwd_hit_b_out,
    output logic                              stall_out,
    output logic                              bubble_out,
    output logic [CNT_WIDTH-1:0]              stall_cnt_out
);

    localparam int              CW       = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LOAD_LAT - 1);

    fsm_state_t     state;
    logic [CW-1:0]  cnt;
    logic           hazard;
    logic           stall;

    fwd_prio_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_SRC        (NUM_SRC)
    ) u_mux_a (
        .addr       (addr_alu_a_in),
        .rf_data    (data_alu_a_in),
        .fwd_addr   (fwd_addr_in),
        .fwd_data   (fwd_data_in),
        .fwd_wr_ena (fwd_wr_ena_in),
        .data       (alu_a_out),
        .hit        (fwd_hit_a_out)
    );

    fwd_prio_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .NUM_SRC        (NUM_SRC)
    ) u_mux_b (
        .addr       (addr_alu_b_in),
        .rf_data    (data_alu_b_in),
        .fwd_addr   (fwd_addr_in),
        .fwd_data   (fwd_data_in),
        .fwd_wr_ena (fwd_wr_ena_in),
        .data       (alu_b_out),
        .hit        (fwd_hit_b_out)
    );

    // Load-use hazard: ID reads the (non-zero) register the EX load is still fetching.
    always_comb begin
        hazard = id_valid_in && ex_load_in
              && (ex_load_dest_in != REG_ADDR_WIDTH'(REG_ZERO))
              && ((id_use_a_in && (id_addr_a_in == ex_load_dest_in))
               || (id_use_b_in && (id_addr_b_in == ex_load_dest_in)));
    end

    // Stall is forced low in reset and on flush; WAIT stalls unconditionally, IDLE only on a hazard.
    always_comb begin
        stall = 1'b0;
        if (rst_n && !flush_in) begin
            stall = (state == ST_WAIT) ? 1'b1 : hazard;
        end
    end

    assign stall_out  = stall;
    assign bubble_out = stall;

    // Stall FSM: the first stall cycle is spent in IDLE, the remaining LOAD_LAT-1 in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (flush_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall && (LOAD_LAT > 1)) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the pipeline was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_out <= '0;
        end else if (stall && (stall_cnt_out != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_out <= stall_cnt_out + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: two instances (LOAD_LAT=1/CNT_WIDTH=16 and LOAD_LAT=3/CNT_WIDTH=4) on shared inputs.
// Expectations are queued with the stimulus and compared by a monitor on the falling edge.
// Each queued entry names the observed output and its hand-computed value.
module tb_forward_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 4;

    localparam int S_A_ALUA  = 0;
    localparam int S_A_HITA  = 1;
    localparam int S_A_ALUB  = 2;
    localparam int S_A_HITB  = 3;
    localparam int S_A_STALL = 4;
    localparam int S_A_BUB   = 5;
    localparam int S_A_CNT   = 6;
    localparam int S_B_STALL = 7;
    localparam int S_B_BUB   = 8;
    localparam int S_B_CNT   = 9;

    logic              clk;
    logic              rst_n;
    logic              flush_in;
    logic [DW-1:0]     data_alu_a_in, data_alu_b_in;
    logic [AW-1:0]     addr_alu_a_in, addr_alu_b_in;
    logic [NS*AW-1:0]  fwd_addr_in;
    logic [NS*DW-1:0]  fwd_data_in;
    logic [NS-1:0]     fwd_wr_ena_in;
    logic              id_valid_in;
    logic [AW-1:0]     id_addr_a_in, id_addr_b_in;
    logic              id_use_a_in, id_use_b_in;
    logic              ex_load_in;
    logic [AW-1:0]     ex_load_dest_in;

    logic [DW-1:0]     a_alu_a, a_alu_b, b_alu_a, b_alu_b;
    logic              a_hit_a, a_hit_b, b_hit_a, b_hit_b;
    logic              a_stall, a_bub, b_stall, b_bub;
    logic [15:0]       a_cnt;
    logic [3:0]        b_cnt;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   total = 0;
    int   bad   = 0;

    forward_hazard_unit #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
        .data_alu_a_in(data_alu_a_in), .data_alu_b_in(data_alu_b_in),
        .addr_alu_a_in(addr_alu_a_in), .addr_alu_b_in(addr_alu_b_in),
        .fwd_addr_in(fwd_addr_in), .fwd_data_in(fwd_data_in), .fwd_wr_ena_in(fwd_wr_ena_in),
        .id_valid_in(id_valid_in), .id_addr_a_in(id_addr_a_in), .id_addr_b_in(id_addr_b_in),
        .id_use_a_in(id_use_a_in), .id_use_b_in(id_use_b_in),
        .ex_load_in(ex_load_in), .ex_load_dest_in(ex_load_dest_in),
        .alu_a_out(a_alu_a), .alu_b_out(a_alu_b),
        .fwd_hit_a_out(a_hit_a), .fwd_hit_b_out(a_hit_b),
        .stall_out(a_stall), .bubble_out(a_bub), .stall_cnt_out(a_cnt)
    );

    forward_hazard_unit #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
        .data_alu_a_in(data_alu_a_in), .data_alu_b_in(data_alu_b_in),
        .addr_alu_a_in(addr_alu_a_in), .addr_alu_b_in(addr_alu_b_in),
        .fwd_addr_in(fwd_addr_in), .fwd_data_in(fwd_data_in), .fwd_wr_ena_in(fwd_wr_ena_in),
        .id_valid_in(id_valid_in), .id_addr_a_in(id_addr_a_in), .id_addr_b_in(id_addr_b_in),
        .id_use_a_in(id_use_a_in), .id_use_b_in(id_use_b_in),
        .ex_load_in(ex_load_in), .ex_load_dest_in(ex_load_dest_in),
        .alu_a_out(b_alu_a), .alu_b_out(b_alu_b),
        .fwd_hit_a_out(b_hit_a), .fwd_hit_b_out(b_hit_b),
        .stall_out(b_stall), .bubble_out(b_bub), .stall_cnt_out(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_A_ALUA:  return a_alu_a;
            S_A_HITA:  return 32'(a_hit_a);
            S_A_ALUB:  return a_alu_b;
            S_A_HITB:  return 32'(a_hit_b);
            S_A_STALL: return 32'(a_stall);
            S_A_BUB:   return 32'(a_bub);
            S_A_CNT:   return 32'(a_cnt);
            S_B_STALL: return 32'(b_stall);
            S_B_BUB:   return 32'(b_bub);
            S_B_CNT:   return 32'(b_cnt);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: drain every expectation queued in this cycle and compare against live outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t c;
            logic [31:0] got;
            c   = sb.pop_front();
            got = actual(c.sel);
            total++;
            if (got !== c.exp) begin
                bad++;
                $display("FAIL %s: got 0x%0h want 0x%0h at %0t", c.name, got, c.exp, $time);
            end
        end
    end

    task automatic exp_push(string nm, int sel, logic [31:0] v);
        chk_t c;
        c.name = nm;
        c.sel  = sel;
        c.exp  = v;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        fwd_addr_in[i*AW +: AW] = a;
        fwd_data_in[i*DW +: DW] = d;
    endtask

    task automatic hazard_a(logic on, logic [AW-1:0] r);
        id_valid_in     = on;
        ex_load_in      = on;
        ex_load_dest_in = r;
        id_use_a_in     = on;
        id_addr_a_in    = r;
        id_use_b_in     = 1'b0;
        id_addr_b_in    = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush_in = 1'b0;
        data_alu_a_in = '0; data_alu_b_in = '0;
        addr_alu_a_in = '0; addr_alu_b_in = '0;
        fwd_addr_in = '0; fwd_data_in = '0; fwd_wr_ena_in = '0;
        hazard_a(1'b1, 5'd7);

        // Reset holds stall low even with a hazard present.
        step();
        exp_push("rst_a_stall", S_A_STALL, 0);
        exp_push("rst_a_bub",   S_A_BUB,   0);
        exp_push("rst_a_cnt",   S_A_CNT,   0);
        exp_push("rst_b_stall", S_B_STALL, 0);
        exp_push("rst_b_cnt",   S_B_CNT,   0);

        step();
        rst_n = 1'b1;
        hazard_a(1'b0, 5'd0);
        data_alu_a_in = 32'h11;
        exp_push("pass_a",     S_A_ALUA, 32'h11);
        exp_push("pass_hit_a", S_A_HITA, 0);

        // Priority among matching sources.
        step();
        addr_alu_a_in = 5'd5;
        set_src(0, 5'd3, 32'h33);
        set_src(1, 5'd5, 32'hAA);
        set_src(2, 5'd2, 32'h22);
        set_src(3, 5'd5, 32'hBB);
        fwd_wr_ena_in = 4'b1111;
        exp_push("prio_src1",     S_A_ALUA, 32'hAA);
        exp_push("prio_src1_hit", S_A_HITA, 1);
        step();
        fwd_wr_ena_in = 4'b1101;
        exp_push("prio_src3",     S_A_ALUA, 32'hBB);
        exp_push("prio_src3_hit", S_A_HITA, 1);
        step();
        set_src(0, 5'd5, 32'hCC);
        fwd_wr_ena_in = 4'b1111;
        exp_push("prio_src0", S_A_ALUA, 32'hCC);
        step();
        addr_alu_b_in = 5'd2;
        data_alu_b_in = 32'h44;
        exp_push("b_src2",     S_A_ALUB, 32'h22);
        exp_push("b_src2_hit", S_A_HITB, 1);
        step();
        fwd_wr_ena_in = 4'b1011;
        exp_push("b_rf",     S_A_ALUB, 32'h44);
        exp_push("b_rf_hit", S_A_HITB, 0);

        // Register 0 never forwards.
        step();
        set_src(0, 5'd0, 32'hFF);
        fwd_wr_ena_in = 4'b0001;
        addr_alu_b_in = 5'd0;
        data_alu_b_in = 32'h0;
        addr_alu_a_in = 5'd0;
        exp_push("r0_b",     S_A_ALUB, 32'h0);
        exp_push("r0_b_hit", S_A_HITB, 0);
        exp_push("r0_a",     S_A_ALUA, 32'h11);
        exp_push("r0_a_hit", S_A_HITA, 0);
        step();
        fwd_wr_ena_in = '0;

        // LOAD_LAT=1: single stall cycle; meanwhile dut_b enters WAIT.
        step();
        hazard_a(1'b1, 5'd7);
        exp_push("ll1_stall", S_A_STALL, 1);
        exp_push("ll1_bub",   S_A_BUB,   1);
        exp_push("ll1_cnt0",  S_A_CNT,   0);
        exp_push("ll3_stall", S_B_STALL, 1);
        step();
        hazard_a(1'b0, 5'd0);
        exp_push("ll1_end",    S_A_STALL, 0);
        exp_push("ll1_cnt1",   S_A_CNT,   1);
        exp_push("ll3_wait",   S_B_STALL, 1);
        exp_push("ll3_wcnt",   S_B_CNT,   1);
        // Asynchronous reset while dut_b is still in WAIT.
        step();
        rst_n = 1'b0;
        exp_push("arst_b_stall", S_B_STALL, 0);
        exp_push("arst_b_cnt",   S_B_CNT,   0);
        exp_push("arst_a_cnt",   S_A_CNT,   0);
        step();
        rst_n = 1'b1;
        id_valid_in = 1'b1; ex_load_in = 1'b1; ex_load_dest_in = 5'd7;
        id_use_a_in = 1'b0; id_addr_a_in = 5'd7;
        id_use_b_in = 1'b1; id_addr_b_in = 5'd3;
        exp_push("nouse_a_stall", S_A_STALL, 0);
        exp_push("nouse_b_stall", S_B_STALL, 0);
        step();
        exp_push("nouse_cnt", S_A_CNT, 0);
        hazard_a(1'b1, 5'd0);
        exp_push("dest0_stall", S_A_STALL, 0);
        step();
        hazard_a(1'b0, 5'd0);
        exp_push("dest0_cnt_a", S_A_CNT, 0);
        exp_push("dest0_cnt_b", S_B_CNT, 0);

        // LOAD_LAT=3: hazard on B gives three stall cycles.
        step();
        id_valid_in = 1'b1; ex_load_in = 1'b1; ex_load_dest_in = 5'd9;
        id_use_b_in = 1'b1; id_addr_b_in = 5'd9;
        exp_push("l3_c0_stall", S_B_STALL, 1);
        exp_push("l3_c0_bub",   S_B_BUB,   1);
        exp_push("l3_c0_cnt",   S_B_CNT,   0);
        exp_push("l3_c0_a",     S_A_STALL, 1);
        step();
        id_valid_in = 1'b0; ex_load_in = 1'b0;
        exp_push("l3_c1_stall", S_B_STALL, 1);
        exp_push("l3_c1_cnt",   S_B_CNT,   1);
        exp_push("l3_c1_a",     S_A_STALL, 0);
        exp_push("l3_c1_acnt",  S_A_CNT,   1);
        step();
        exp_push("l3_c2_stall", S_B_STALL, 1);
        exp_push("l3_c2_cnt",   S_B_CNT,   2);
        step();
        exp_push("l3_c3_stall", S_B_STALL, 0);
        exp_push("l3_c3_bub",   S_B_BUB,   0);
        exp_push("l3_c3_cnt",   S_B_CNT,   3);
        step();
        exp_push("l3_c4_stall", S_B_STALL, 0);
        exp_push("l3_c4_cnt",   S_B_CNT,   3);

        // Flush in the second stall cycle aborts the stall.
        step();
        rst_n = 1'b0;
        exp_push("fl_rst_cnt", S_B_CNT, 0);
        step();
        rst_n = 1'b1;
        step();
        id_valid_in = 1'b1; ex_load_in = 1'b1;
        exp_push("fl_c0_stall", S_B_STALL, 1);
        exp_push("fl_c0_cnt",   S_B_CNT,   0);
        step();
        flush_in = 1'b1;
        exp_push("fl_c1_stall", S_B_STALL, 0);
        exp_push("fl_c1_bub",   S_B_BUB,   0);
        exp_push("fl_c1_cnt",   S_B_CNT,   1);
        exp_push("fl_c1_a",     S_A_STALL, 0);
        step();
        flush_in = 1'b0;
        id_valid_in = 1'b0; ex_load_in = 1'b0;
        exp_push("fl_c2_idle", S_B_STALL, 0);
        exp_push("fl_c2_cnt",  S_B_CNT,   1);
        step();
        exp_push("fl_c3_cnt", S_B_CNT, 1);

        // Continuous hazard: 4-bit counter saturates, 16-bit keeps counting.
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hazard_a(1'b1, 5'd4);
        for (int k = 0; k < 20; k++) begin
            exp_push($sformatf("sat_b_stall_%0d", k), S_B_STALL, 1);
            exp_push($sformatf("sat_b_cnt_%0d", k),   S_B_CNT,   (k > 15) ? 15 : k);
            exp_push($sformatf("sat_a_cnt_%0d", k),   S_A_CNT,   k);
            step();
        end
        // dut_b is in WAIT here; reset must clear it before any clock edge.
        hazard_a(1'b0, 5'd0);
        rst_n = 1'b0;
        exp_push("sat_arst_b_stall", S_B_STALL, 0);
        exp_push("sat_arst_b_cnt",   S_B_CNT,   0);
        exp_push("sat_arst_a_cnt",   S_A_CNT,   0);
        step();
        rst_n = 1'b1;
        step();
        exp_push("post_idle_b", S_B_STALL, 0);
        step();
        step();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
